// File: rtl/button_poller_pkg.sv
// button_poller_pkg: shared states, event codes, AHB constants and register map for the button poller
package button_poller_pkg;
  typedef enum logic [2:0] {
    ST_WAIT, ST_REQ, ST_ADDR_ND, ST_DATA_ND, ST_ADDR_FLAG, ST_DATA_FLAG, ST_RELEASE
  } state_e;
  typedef enum logic [1:0] {EV_DAY_NIGHT, EV_MODE, EV_TRIP, EV_SETTING} event_e;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [31:0] OFF_DAY_NIGHT = 32'd0;
  localparam logic [31:0] OFF_MODE = 32'd4;
  localparam logic [31:0] OFF_TRIP = 32'd8;
  localparam logic [31:0] OFF_SETTING = 32'd12;
  localparam logic [31:0] OFF_NEW_DATA = 32'd16;
  function automatic logic [31:0] flag_off(input event_e idx);
    return idx == EV_DAY_NIGHT ? OFF_DAY_NIGHT :
           idx == EV_MODE      ? OFF_MODE      :
           idx == EV_TRIP      ? OFF_TRIP      : OFF_SETTING;
  endfunction
endpackage

// File: rtl/event_fifo.sv
// event_fifo: small FIFO with extra-bit wrap pointers; a push while full is accepted only alongside a pop
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
endmodule

// File: rtl/button_event_poller.sv
// button_event_poller: periodically polls a button register block over AHB-Lite and queues the first set flag
module button_event_poller
  import button_poller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int POLL_PERIOD = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  output logic        BusReq,
  input  logic        BusGnt,
  output logic        EventValid,
  output logic [1:0]  EventCode,
  input  logic        EventPop,
  output logic        Irq,
  output logic        Overflow,
  input  logic        OverflowClr
);
  localparam logic [15:0] CNT_LAST = 16'(POLL_PERIOD - 1);
  state_e state_q, state_d;
  event_e idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, push, full, empty, rd_bit, last_flag, unused_hrdata;
  assign rd_bit = HRDATA[0];
  assign unused_hrdata = ^HRDATA[31:1];
  assign last_flag = rd_bit || idx_q == EV_SETTING;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    case (state_q)
      ST_WAIT: begin
        state_d = cnt_q == CNT_LAST ? ST_REQ : ST_WAIT;
        cnt_d = cnt_q == CNT_LAST ? '0 : cnt_q + 16'd1;
      end
      ST_REQ: state_d = BusGnt ? ST_ADDR_ND : ST_REQ;
      ST_ADDR_ND: state_d = HREADY ? ST_DATA_ND : ST_ADDR_ND;
      ST_DATA_ND: if (HREADY) begin
        state_d = rd_bit ? ST_ADDR_FLAG : ST_RELEASE;
        idx_d = rd_bit ? EV_DAY_NIGHT : idx_q;
      end
      ST_ADDR_FLAG: state_d = HREADY ? ST_DATA_FLAG : ST_ADDR_FLAG;
      // reading a set flag clears them all in the slave, so stop at the first one
      ST_DATA_FLAG: if (HREADY) begin
        state_d = last_flag ? ST_RELEASE : ST_ADDR_FLAG;
        idx_d = last_flag ? idx_q : event_e'(idx_q + 2'd1);
      end
      default: state_d = ST_WAIT;
    endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_WAIT;
      cnt_q <= '0;
      idx_q <= EV_DAY_NIGHT;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end
  assign push = state_q == ST_DATA_FLAG && HREADY && rd_bit;
  assign ovf_d = (push && full && !EventPop) || (ovf_q && !OverflowClr);
  assign HTRANS = state_q inside {ST_ADDR_ND, ST_ADDR_FLAG} ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR = state_q == ST_ADDR_ND   ? BASE_ADDR + OFF_NEW_DATA :
                 state_q == ST_ADDR_FLAG ? BASE_ADDR + flag_off(idx_q) : BASE_ADDR;
  assign BusReq = !(state_q inside {ST_WAIT, ST_RELEASE});
  assign HWRITE = 1'b0;
  assign HSIZE = 3'b010;
  assign HWDATA = '0;
  assign EventValid = !empty;
  assign Irq = !empty;
  assign Overflow = ovf_q;
  event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(2)) u_fifo (
    .clk(HCLK), .rst(HRESET), .push(push), .pop(EventPop), .wdata(idx_q),
    .rdata(EventCode), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_button_event_poller.sv
// tb_button_event_poller: directed scenarios against a small button-register slave model
module tb_button_event_poller;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic HCLK = 0, HRESET = 1, HREADY = 1, BusGnt = 1, EventPop = 0, OverflowClr = 0;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0] HTRANS, EventCode;
  logic [2:0] HSIZE;
  logic HWRITE, BusReq, EventValid, Irq, Overflow;
  logic nd = 0;
  logic [3:0] fl = 0;
  logic [31:0] daddr = 0;
  logic [31:0] log_a [0:1023];
  int nlog = 0, checks = 0, errs = 0;

  button_event_poller #(.BASE_ADDR(BASE), .POLL_PERIOD(8), .FIFO_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .BusReq(BusReq),
    .BusGnt(BusGnt), .EventValid(EventValid), .EventCode(EventCode), .EventPop(EventPop),
    .Irq(Irq), .Overflow(Overflow), .OverflowClr(OverflowClr)
  );

  always #5 HCLK = ~HCLK;
  // slave: address phase latched on HREADY, data returned combinationally in the data phase
  assign HRDATA = {31'd0, (daddr == BASE + 32'h10) ? nd : fl[daddr[3:2]]};
  always @(posedge HCLK) if (HTRANS == 2'b10 && HREADY) begin
    daddr <= HADDR;
    log_a[10'(nlog)] <= HADDR;
    nlog <= nlog + 1;
  end

  function automatic logic [31:0] logged(input int k);
    return log_a[10'(k)];
  endfunction

  task automatic idle_sync();
    for (int i = 0; i < 40 && BusReq !== 1'b0; i++) @(negedge HCLK);
    checks++; if (BusReq !== 1'b0) begin errs++; $display("FAIL idle_sync: BusReq got %b exp 0", BusReq); end
  endtask

  task automatic wait_addr_nd(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge HCLK);
      if (HTRANS === 2'b10 && HADDR === BASE + 32'h10) begin ok = 1; break; end
    end
  endtask

  task automatic pop1();
    EventPop = 1; @(negedge HCLK); EventPop = 0;
  endtask

  // rel = cycles from the NewData address phase to RELEASE, -1 on timeout
  task automatic poll(input logic nd_v, input logic [3:0] fl_v, output int st, output int rel, output logic ev_pre);
    logic pre;
    bit ok;
    idle_sync();
    nd = nd_v; fl = fl_v; st = nlog; rel = -1; ev_pre = 1'bx;
    wait_addr_nd(ok);
    if (ok) for (int n = 1; n <= 20; n++) begin
      pre = EventValid;
      @(negedge HCLK);
      if (!BusReq) begin rel = n; ev_pre = pre; break; end
    end
    nd = 0; fl = 0;
  endtask

  task automatic test_reset();
    HRESET = 1; repeat (3) @(posedge HCLK); @(negedge HCLK);
    checks++; if (BusReq !== 1'b0) begin errs++; $display("FAIL rst_busreq: got %b exp 0", BusReq); end
    checks++; if (HTRANS !== 2'b00) begin errs++; $display("FAIL rst_htrans: got %b exp 00", HTRANS); end
    checks++; if (HADDR !== BASE) begin errs++; $display("FAIL rst_haddr: got %h exp %h", HADDR, BASE); end
    checks++; if (HWRITE !== 1'b0 || HSIZE !== 3'b010 || HWDATA !== 32'd0) begin errs++; $display("FAIL rst_const: got %b/%b/%h exp 0/010/0", HWRITE, HSIZE, HWDATA); end
    checks++; if (EventValid !== 1'b0 || Irq !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b/%b exp 0/0", EventValid, Irq); end
    checks++; if (EventCode !== 2'd0) begin errs++; $display("FAIL rst_code: got %0d exp 0", EventCode); end
    checks++; if (Overflow !== 1'b0) begin errs++; $display("FAIL rst_ovf: got %b exp 0", Overflow); end
    HRESET = 0;
  endtask

  task automatic test_idle_poll();
    int n = 0, first = -1, prev = -1, bad_gap = 0, bad_addr = 0, ev = 0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge HCLK);
      if (EventValid !== 1'b0) ev++;
      if (HTRANS === 2'b10) begin
        if (HADDR !== BASE + 32'h10) bad_addr++;
        if (n == 0) first = c; else if (c - prev != 12) bad_gap++;
        prev = c; n++;
      end
    end
    checks++; if (n != 3) begin errs++; $display("FAIL idle_reads: got %0d exp 3", n); end
    checks++; if (first != 9) begin errs++; $display("FAIL idle_first: got %0d exp 9", first); end
    checks++; if (bad_gap != 0) begin errs++; $display("FAIL idle_period: got %0d bad gaps exp 0", bad_gap); end
    checks++; if (bad_addr != 0) begin errs++; $display("FAIL idle_addr: got %0d bad addrs exp 0", bad_addr); end
    checks++; if (ev != 0) begin errs++; $display("FAIL idle_empty: got %0d valid cycles exp 0", ev); end
  endtask

  task automatic test_trip();
    int st, rel;
    logic pre;
    poll(1, 4'b0100, st, rel, pre);
    checks++; if (rel != 8) begin errs++; $display("FAIL trip_latency: got %0d exp 8", rel); end
    checks++; if (pre !== 1'b0) begin errs++; $display("FAIL trip_valid_early: got %b exp 0", pre); end
    checks++; if (EventValid !== 1'b1 || Irq !== 1'b1) begin errs++; $display("FAIL trip_valid: got %b/%b exp 1/1", EventValid, Irq); end
    checks++; if (EventCode !== 2'd2) begin errs++; $display("FAIL trip_code: got %0d exp 2", EventCode); end
    checks++; if (nlog - st != 4) begin errs++; $display("FAIL trip_nreads: got %0d exp 4", nlog - st); end
    checks++; if (logged(st) !== BASE + 32'h10 || logged(st + 1) !== BASE) begin errs++; $display("FAIL trip_addr01: got %h %h exp %h %h", logged(st), logged(st + 1), BASE + 32'h10, BASE); end
    checks++; if (logged(st + 2) !== BASE + 32'h4 || logged(st + 3) !== BASE + 32'h8) begin errs++; $display("FAIL trip_addr23: got %h %h exp %h %h", logged(st + 2), logged(st + 3), BASE + 32'h4, BASE + 32'h8); end
    pop1();
    checks++; if (EventValid !== 1'b0 || Irq !== 1'b0) begin errs++; $display("FAIL trip_pop: got %b/%b exp 0/0", EventValid, Irq); end
  endtask

  task automatic test_no_flag();
    int st, rel;
    logic pre;
    poll(1, 4'b0000, st, rel, pre);
    checks++; if (rel != 10) begin errs++; $display("FAIL noflag_latency: got %0d exp 10", rel); end
    checks++; if (nlog - st != 5) begin errs++; $display("FAIL noflag_nreads: got %0d exp 5", nlog - st); end
    checks++; if (logged(st + 4) !== BASE + 32'hC) begin errs++; $display("FAIL noflag_last: got %h exp %h", logged(st + 4), BASE + 32'hC); end
    checks++; if (EventValid !== 1'b0) begin errs++; $display("FAIL noflag_push: got %b exp 0", EventValid); end
  endtask

  task automatic test_flag_order();
    int st, rel;
    logic pre;
    logic [1:0] exp_c [3] = '{2'd0, 2'd3, 2'd1};
    pop1();
    checks++; if (EventValid !== 1'b0) begin errs++; $display("FAIL empty_pop: got %b exp 0", EventValid); end
    poll(1, 4'b0001, st, rel, pre);
    checks++; if (rel != 4) begin errs++; $display("FAIL order_lat0: got %0d exp 4", rel); end
    checks++; if (EventValid !== 1'b1 || EventCode !== 2'd0) begin errs++; $display("FAIL order_first: got %b/%0d exp 1/0", EventValid, EventCode); end
    poll(1, 4'b1000, st, rel, pre);
    checks++; if (rel != 10) begin errs++; $display("FAIL order_lat3: got %0d exp 10", rel); end
    poll(1, 4'b0110, st, rel, pre);
    checks++; if (rel != 6) begin errs++; $display("FAIL order_lat1: got %0d exp 6", rel); end
    checks++; if (nlog - st != 3) begin errs++; $display("FAIL order_priority_reads: got %0d exp 3", nlog - st); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (EventCode !== exp_c[j]) begin errs++; $display("FAIL order_code%0d: got %0d exp %0d", j, EventCode, exp_c[j]); end
      pop1();
    end
    checks++; if (EventValid !== 1'b0) begin errs++; $display("FAIL order_empty: got %b exp 0", EventValid); end
  endtask

  task automatic test_bus_grant();
    int i = 0, bad = 0, st;
    idle_sync();
    BusGnt = 0;
    while (BusReq !== 1'b1 && i < 30) begin @(negedge HCLK); i++; end
    checks++; if (BusReq !== 1'b1) begin errs++; $display("FAIL gnt_req: got %b exp 1", BusReq); end
    st = nlog;
    repeat (20) begin @(negedge HCLK); if (BusReq !== 1'b1 || HTRANS !== 2'b00) bad++; end
    checks++; if (bad != 0) begin errs++; $display("FAIL gnt_hold: got %0d bad cycles exp 0", bad); end
    checks++; if (nlog != st) begin errs++; $display("FAIL gnt_noread: got %0d reads exp 0", nlog - st); end
    BusGnt = 1;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b10 || HADDR !== BASE + 32'h10) begin errs++; $display("FAIL gnt_first_nonseq: got %b/%h exp 10/%h", HTRANS, HADDR, BASE + 32'h10); end
  endtask

  task automatic test_hready_stall();
    bit ok;
    int bad = 0, i = 0;
    idle_sync();
    nd = 1; fl = 4'b0010;
    wait_addr_nd(ok);
    checks++; if (!ok) begin errs++; $display("FAIL stall_addr_nd: got timeout exp ADDR_ND"); end
    HREADY = 0;
    repeat (2) begin @(negedge HCLK); if (HTRANS !== 2'b10 || HADDR !== BASE + 32'h10) bad++; end
    checks++; if (bad != 0) begin errs++; $display("FAIL stall_addr_hold: got %0d bad cycles exp 0", bad); end
    HREADY = 1;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00 || BusReq !== 1'b1) begin errs++; $display("FAIL stall_data_enter: got %b/%b exp 00/1", HTRANS, BusReq); end
    HREADY = 0; nd = 0; bad = 0;
    repeat (3) begin @(negedge HCLK); if (BusReq !== 1'b1 || HTRANS !== 2'b00 || HADDR !== BASE) bad++; end
    checks++; if (bad != 0) begin errs++; $display("FAIL stall_data_hold: got %0d bad cycles exp 0", bad); end
    nd = 1; HREADY = 1;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b10 || HADDR !== BASE) begin errs++; $display("FAIL stall_sample: got %b/%h exp 10/%h", HTRANS, HADDR, BASE); end
    while (EventValid !== 1'b1 && i < 20) begin @(negedge HCLK); i++; end
    nd = 0; fl = 0;
    checks++; if (EventValid !== 1'b1 || EventCode !== 2'd1) begin errs++; $display("FAIL stall_event: got %b/%0d exp 1/1", EventValid, EventCode); end
    pop1();
    checks++; if (EventValid !== 1'b0) begin errs++; $display("FAIL stall_pop: got %b exp 0", EventValid); end
  endtask

  task automatic test_overflow();
    int st, rel;
    logic pre;
    bit ok;
    for (int j = 0; j < 4; j++) begin
      poll(1, 4'b0010, st, rel, pre);
      checks++; if (rel != 6) begin errs++; $display("FAIL ovf_fill%0d: got %0d exp 6", j, rel); end
    end
    checks++; if (Overflow !== 1'b0 || EventValid !== 1'b1) begin errs++; $display("FAIL ovf_full: got %b/%b exp 0/1", Overflow, EventValid); end
    poll(1, 4'b0010, st, rel, pre);
    checks++; if (Overflow !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b exp 1", Overflow); end
    checks++; if (EventCode !== 2'd1) begin errs++; $display("FAIL ovf_head: got %0d exp 1", EventCode); end
    OverflowClr = 1; @(negedge HCLK); OverflowClr = 0;
    checks++; if (Overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr: got %b exp 0", Overflow); end
    idle_sync();
    nd = 1; fl = 4'b0010;
    wait_addr_nd(ok);
    checks++; if (!ok) begin errs++; $display("FAIL ovf_collide_start: got timeout exp ADDR_ND"); end
    repeat (5) @(negedge HCLK);
    OverflowClr = 1; @(negedge HCLK); OverflowClr = 0;
    nd = 0; fl = 0;
    checks++; if (Overflow !== 1'b1 || BusReq !== 1'b0) begin errs++; $display("FAIL ovf_clr_collide: got %b/%b exp 1/0", Overflow, BusReq); end
    OverflowClr = 1; @(negedge HCLK); OverflowClr = 0;
    checks++; if (Overflow !== 1'b0) begin errs++; $display("FAIL ovf_clr2: got %b exp 0", Overflow); end
  endtask

  task automatic test_push_pop_full();
    bit ok;
    logic [1:0] exp_c [4] = '{2'd1, 2'd1, 2'd1, 2'd3};
    idle_sync();
    nd = 1; fl = 4'b1000;
    wait_addr_nd(ok);
    checks++; if (!ok) begin errs++; $display("FAIL pp_start: got timeout exp ADDR_ND"); end
    repeat (9) @(negedge HCLK);
    EventPop = 1; @(negedge HCLK); EventPop = 0;
    nd = 0; fl = 0;
    checks++; if (BusReq !== 1'b0 || Overflow !== 1'b0) begin errs++; $display("FAIL pp_no_ovf: got %b/%b exp 0/0", BusReq, Overflow); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (EventValid !== 1'b1 || EventCode !== exp_c[j]) begin errs++; $display("FAIL pp_code%0d: got %b/%0d exp 1/%0d", j, EventValid, EventCode, exp_c[j]); end
      pop1();
    end
    checks++; if (EventValid !== 1'b0 || Irq !== 1'b0) begin errs++; $display("FAIL pp_empty: got %b/%b exp 0/0", EventValid, Irq); end
  endtask

  task automatic test_reset_mid();
    int st, rel, first = -1;
    logic pre;
    bit ok;
    poll(1, 4'b0001, st, rel, pre);
    checks++; if (EventValid !== 1'b1) begin errs++; $display("FAIL rmid_prefill: got %b exp 1", EventValid); end
    idle_sync();
    nd = 1; fl = 4'b0100;
    wait_addr_nd(ok);
    repeat (2) @(negedge HCLK);
    checks++; if (!ok || HTRANS !== 2'b10 || HADDR !== BASE) begin errs++; $display("FAIL rmid_addr_flag: got %b/%h exp 10/%h", HTRANS, HADDR, BASE); end
    HRESET = 1; HREADY = 0;
    @(negedge HCLK);
    checks++; if (HTRANS !== 2'b00 || BusReq !== 1'b0 || HADDR !== BASE) begin errs++; $display("FAIL rmid_bus: got %b/%b/%h exp 00/0/%h", HTRANS, BusReq, HADDR, BASE); end
    checks++; if (EventValid !== 1'b0 || Irq !== 1'b0 || EventCode !== 2'd0) begin errs++; $display("FAIL rmid_fifo: got %b/%b/%0d exp 0/0/0", EventValid, Irq, EventCode); end
    HRESET = 0; HREADY = 1; nd = 0; fl = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge HCLK);
      if (HTRANS === 2'b10) begin first = c; break; end
    end
    checks++; if (first != 9) begin errs++; $display("FAIL rmid_wait_restart: got %0d exp 9", first); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got still running exp finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_poll();
    test_trip();
    test_no_flag();
    test_flag_order();
    test_bus_grant();
    test_hready_stall();
    test_overflow();
    test_push_pop_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
